// File: rtl/instr_encode_loader.sv
// Encodes MIPS instruction field bundles into 32-bit words and writes them to
// instruction memory at sequential addresses, one word every two cycles.
module instr_encode_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);

  // state | meaning
  // IDLE  | waiting for start
  // LOAD  | in_ready high, accepting one field bundle
  // WRITE | imem_we high for the latched word
  // DONE  | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t      state, state_nxt;
  logic [31:0] enc_word;
  logic        kind_legal;
  logic        accept;
  logic        last_q;
  logic        at_end;

  always_comb begin
    enc_word   = '0;
    kind_legal = 1'b1;
    case (kind)
      3'd0:    enc_word = {6'b000000, rs, rt, rd, shamt, funct};
      3'd1:    enc_word = {6'b100011, rs, rt, imm};
      3'd2:    enc_word = {6'b101011, rs, rt, imm};
      3'd3:    enc_word = {6'b000100, rs, rt, imm};
      3'd4:    enc_word = {6'b001000, rs, rt, imm};
      3'd5:    enc_word = {6'b000010, target};
      default: kind_legal = 1'b0;
    endcase
  end

  // in_ready is registered and only high in LOAD, so it doubles as the state qualifier
  assign accept = in_valid && in_ready;
  assign at_end = last_q || (imem_addr == ADDR_MAX);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD: begin
        if (accept) begin
          if (kind_legal)   state_nxt = WRITE;
          else if (in_last) state_nxt = DONE;
        end
      end
      WRITE:   state_nxt = at_end ? DONE : LOAD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= ADDR_BASE;
      imem_wdata <= '0;
      count      <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      in_ready <= (state_nxt == LOAD);
      imem_we  <= (state_nxt == WRITE);
      done     <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            imem_addr <= ADDR_BASE;
            count     <= '0;
            err       <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (kind_legal) begin
              imem_wdata <= enc_word;
              last_q     <= in_last;
            end else begin
              err <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (count != COUNT_MAX) count <= count + (ADDR_W+1)'(1);
          // the top address is terminal: stop there rather than wrap
          if (!at_end) imem_addr <= imem_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Encoder counterpart of the opcode decoder in the single-cycle MIPS core.
- Accepts instruction fields over a valid/ready handshake and encodes them into 32-bit MIPS words.
- Writes each word into instruction memory at sequential addresses.
- Used to load test programs that the core's control unit then decodes. Supported kinds: R-type, lw, sw, beq, addi, j.

Parameters:
ADDR_W, 8, word-address width of instruction memory; capacity 2^ADDR_W words
BASE_ADDR, 0, first word address written after each start

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a load session
in_valid  input  1  field bundle valid
in_ready  output  1  block can accept a bundle
in_last  input  1  bundle is the final instruction of the session
kind  input  3  0=R, 1=lw, 2=sw, 3=beq, 4=addi, 5=j; 6,7 illegal
rs  input  5  source register
rt  input  5  target register
rd  input  5  destination register (R only)
shamt  input  5  shift amount (R only)
funct  input  6  function code (R only)
imm  input  16  immediate / offset (I-type)
target  input  26  jump target (j only)
imem_we  output  1  instruction memory write strobe
imem_addr  output  ADDR_W  write word address
imem_wdata  output  32  encoded instruction
count  output  ADDR_W+1  words written in current session
done  output  1  one-cycle pulse at end of session
err  output  1  sticky: illegal kind seen since last start

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, done=0, err=0.
- All outputs are registered.
- Encoding:
  - R: {6'b000000, rs, rt, rd, shamt, funct}
  - lw: {6'b100011, rs, rt, imm}
  - sw: {6'b101011, rs, rt, imm}
  - beq: {6'b000100, rs, rt, imm}
  - addi: {6'b001000, rs, rt, imm}
  - j: {6'b000010, target}
  - Fields irrelevant to a kind are ignored.
- IDLE: in_ready=0. start -> LOAD; on the same edge set imem_addr=BASE_ADDR, count=0, err=0.
- LOAD: in_ready=1. A transfer occurs on a clock edge with in_valid && in_ready.
  - Legal kind: latch encoded word into imem_wdata and latch in_last; -> WRITE.
  - Illegal kind: bundle is consumed but not written; err<=1; remain LOAD. If in_last is also set -> DONE.
- WRITE: in_ready=0, imem_we=1 for exactly one cycle with the current imem_addr and imem_wdata. Then:
  - count increments.
  - Latched last set, or imem_addr == 2^ADDR_W-1 (memory full): -> DONE, and imem_addr does not wrap.
  - Otherwise imem_addr increments and the state returns to LOAD.
- DONE: done=1 for one cycle, in_ready=0; -> IDLE.
- Throughput: one word per 2 cycles. Write occurs the cycle after acceptance.
- start outside IDLE is ignored.
- Bundles presented while in_ready=0 are not consumed; the source holds them.
- Reset mid-session: the write is aborted immediately, imem_we drops asynchronously, and the session is lost.
- count saturates at 2^ADDR_W. imem_wdata holds its last value when imem_we=0.

Test Plan:
- Reset then start; send R rs=1 rt=2 rd=3 shamt=0 funct=0x20 -> imem_we at addr 0, wdata 0x00221820, count=1.
- Sequence of 5 bundles, last on the 5th:
  - lw rs=1 rt=2 imm=4 -> 0x8C220004
  - sw imm=8 -> 0xAC220008
  - beq imm=0xFFFF -> 0x1022FFFF
  - addi rs=0 rt=1 imm=5 -> 0x20010005
  - j target=0x10 -> 0x08000010
  - Required: addresses 0..4, done pulse after 5th write, count=5.
- Illegal kind=7 mid-stream -> no imem_we for it, err=1, next legal bundle written at the next unused address. A new start clears err.
- ADDR_W=2: send 6 bundles without in_last -> writes at 0..3, done after 4th, in_ready=0 afterwards, no wrap to 0.
- in_valid held high while in_ready=0 in WRITE -> bundle accepted exactly once, only after returning to LOAD.
- Assert rst_n=0 during WRITE -> imem_we falls without a clock edge, outputs at reset values; start again writes at BASE_ADDR.
